// File: rtl/countdown_timer.sv
// countdown_timer: six-digit BCD MM:SS.cc countdown with button preset entry, pause and expiry alarm

// countdown_debounce: 2-FF synchronizer plus stability debouncer emitting one pulse per accepted press
module countdown_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES) < 1 ? 1 : $clog2(DEB_CYCLES);
  logic s1, s2, lvl;
  logic [CW-1:0] cnt;
  // accept a new level once the synchronized input has disagreed with it for DEB_CYCLES samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      lvl <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
        press <= lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module countdown_timer #(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_start,
  input  logic       pb_min,
  input  logic       pb_sec,
  input  logic       pb_clr,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic       running,
  output logic       alarm
);
  localparam int PW = $clog2(TICK_DIV) < 1 ? 1 : $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [15:0]   preset;
  logic [23:0]   count;
  logic [23:0]   next_count;
  logic [23:0]   disp;
  logic [PW-1:0] pre;
  logic          tick;
  logic          p_start, p_min, p_sec, p_clr;

  countdown_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (.clk(clk), .rst(rst), .pin(pb_start), .press(p_start));
  countdown_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_min   (.clk(clk), .rst(rst), .pin(pb_min),   .press(p_min));
  countdown_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sec   (.clk(clk), .rst(rst), .pin(pb_sec),   .press(p_sec));
  countdown_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr   (.clk(clk), .rst(rst), .pin(pb_clr),   .press(p_clr));

  // BCD +1 on a two-digit 00..59 field, wrapping 59 back to 00
  function automatic logic [7:0] inc59(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] == 4'd5 ? 4'd0 : v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  // one-centisecond BCD decrement; tens of seconds and minutes borrow from 0 to 5, all others 0 to 9
  function automatic logic [23:0] dec_bcd(input logic [23:0] c);
    logic [23:0] r;
    logic        b;
    logic [3:0]  lim;
    r = c;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (b) begin
        r[i*4+:4] = c[i*4+:4] == 4'd0 ? lim : c[i*4+:4] - 4'd1;
        b = c[i*4+:4] == 4'd0;
      end
    end
    return r;
  endfunction

  // active-low gfedcba digit code, blank for non-decimal values
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  // tick qualifies the prescaler wrap and the display source follows the registered state
  always_comb begin
    tick = (state == RUN) && (pre == PW'(TICK_DIV - 1));
    next_count = dec_bcd(count);
    disp = state == IDLE ? {preset, 8'h00} : state == DONE ? 24'h0 : count;
  end

  assign seg0 = seg7(disp[3:0]);
  assign seg1 = seg7(disp[7:4]);
  assign seg2 = seg7(disp[11:8]);
  assign seg3 = seg7(disp[15:12]);
  assign seg4 = seg7(disp[19:16]);
  assign seg5 = seg7(disp[23:20]);

  // control FSM: clr overrides everything, then start, then the preset buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      preset <= '0;
      count <= '0;
      pre <= '0;
      running <= 1'b0;
      alarm <= 1'b0;
    end else if (p_clr) begin
      state <= IDLE;
      count <= '0;
      pre <= '0;
      running <= 1'b0;
      alarm <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p_start) begin
            if (preset != 16'h0) begin
              count <= {preset, 8'h00};
              pre <= '0;
              state <= RUN;
              running <= 1'b1;
            end
          end else if (p_min) begin
            preset[15:8] <= inc59(preset[15:8]);
          end else if (p_sec) begin
            preset[7:0] <= inc59(preset[7:0]);
          end
        end
        RUN: begin
          if (p_start) begin
            pre <= '0;
            state <= PAUSE;
            running <= 1'b0;
          end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
              count <= next_count;
              if (next_count == 24'h0) begin
                state <= DONE;
                running <= 1'b0;
                alarm <= 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (p_start) begin
            pre <= '0;
            state <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          if (p_start) begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized press sequences scored against a centisecond-arithmetic model
module tb_countdown_timer;
  localparam int TD = 4;
  localparam int DB = 2;
  localparam int LAT = DB + 3;
  localparam logic [3:0] START = 4'b0001, MIN = 4'b0010, SEC = 4'b0100, CLR = 4'b1000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_start = 1'b1, pb_min = 1'b1, pb_sec = 1'b1, pb_clr = 1'b1;
  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
  logic running, alarm;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          e;
    logic [41:0] seg;
    logic        r;
    logic        a;
    string       name;
  } exp_t;
  exp_t q[$];
  exp_t mx;

  int mst, pm, ps, run_t, run_cs, hold_cs, last_pe;

  countdown_timer #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .pb_start(pb_start), .pb_min(pb_min), .pb_sec(pb_sec), .pb_clr(pb_clr),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5),
    .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cs_at(int e);
    int v;
    v = run_cs - (e - run_t) / TD;
    return v < 0 ? 0 : v;
  endfunction

  function automatic logic [41:0] show(int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {SEG[mm / 10], SEG[mm % 10], SEG[ss / 10], SEG[ss % 10], SEG[cc / 10], SEG[cc % 10]};
  endfunction

  task automatic push(int e, string name);
    exp_t x;
    int cs, i;
    x.e = e;
    x.name = name;
    x.r = 1'b0;
    x.a = 1'b0;
    cs = 0;
    case (mst)
      M_IDLE: cs = (pm * 60 + ps) * 100;
      M_RUN: begin
        cs = cs_at(e);
        x.r = cs != 0;
        x.a = cs == 0;
      end
      M_PAUSE: cs = hold_cs;
      default: x.a = 1'b1;
    endcase
    x.seg = show(cs);
    i = q.size();
    while (i > 0 && q[i-1].e > e) i--;
    q.insert(i, x);
  endtask

  task automatic apply(logic [3:0] mask, int pe);
    if (mst == M_RUN) begin
      hold_cs = cs_at(pe - 1);
      if (hold_cs == 0) mst = M_DONE;
    end
    if (mask[3]) mst = M_IDLE;
    else if (mask[0]) begin
      case (mst)
        M_IDLE: if (pm != 0 || ps != 0) begin
          mst = M_RUN;
          run_t = pe;
          run_cs = (pm * 60 + ps) * 100;
        end
        M_RUN: mst = M_PAUSE;
        M_PAUSE: begin
          mst = M_RUN;
          run_t = pe;
          run_cs = hold_cs;
        end
        default: mst = M_IDLE;
      endcase
    end else if (mask[1]) begin
      if (mst == M_IDLE) pm = (pm + 1) % 60;
    end else if (mask[2]) begin
      if (mst == M_IDLE) ps = (ps + 1) % 60;
    end
    last_pe = pe;
    push(pe, "press edge");
    push(pe + 3, "press+3");
    push(pe + 4, "press+4");
  endtask

  task automatic drive(logic [3:0] mask, logic low);
    if (mask[0]) pb_start = !low;
    if (mask[1]) pb_min = !low;
    if (mask[2]) pb_sec = !low;
    if (mask[3]) pb_clr = !low;
  endtask

  task automatic press(logic [3:0] mask, logic bounce);
    @(negedge clk);
    drive(mask, 1'b1);
    apply(mask, cyc + LAT);
    repeat (6 + $urandom_range(3)) @(negedge clk);
    if (bounce) begin
      repeat (3) begin
        drive(mask, 1'b0);
        @(negedge clk);
        drive(mask, 1'b1);
        @(negedge clk);
      end
    end
    drive(mask, 1'b0);
    repeat (7) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].e <= cyc) begin
      mx = q.pop_front();
      checks++;
      if (mx.e < cyc) begin
        errors++;
        $display("FAIL %s stale check at cycle %0d, due %0d", mx.name, cyc, mx.e);
      end
      checks++;
      if ({seg5, seg4, seg3, seg2, seg1, seg0} !== mx.seg) begin
        errors++;
        $display("FAIL %s seg @%0d got %h want %h", mx.name, cyc, {seg5, seg4, seg3, seg2, seg1, seg0}, mx.seg);
      end
      checks++;
      if (running !== mx.r) begin
        errors++;
        $display("FAIL %s running @%0d got %b want %b", mx.name, cyc, running, mx.r);
      end
      checks++;
      if (alarm !== mx.a) begin
        errors++;
        $display("FAIL %s alarm @%0d got %b want %b", mx.name, cyc, alarm, mx.a);
      end
    end
  end

  initial begin
    logic [3:0] pick [7];
    pick = '{START, MIN, SEC, CLR, START | MIN, CLR | START, MIN | SEC};
    mst = M_IDLE;
    pm = 0;
    ps = 0;
    run_t = 0;
    run_cs = 0;
    hold_cs = 0;
    last_pe = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(cyc + 1, "reset state");
    push(cyc + 3, "reset idle");
    repeat (5) @(negedge clk);
    press(START, 1'b0);
    for (int i = 0; i < 61; i++) press(MIN, i == 30);
    press(SEC, 1'b0);
    press(SEC, 1'b1);
    push(cyc + 2, "preset 01:02");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 59; i++) press(MIN, 1'b0);
    for (int i = 0; i < 59; i++) press(SEC, 1'b0);
    press(START, 1'b0);
    push(last_pe + 20 + $urandom_range(370), "run random");
    push(last_pe + 399, "last centisecond");
    push(last_pe + 400, "expiry");
    push(last_pe + 405, "done hold");
    repeat (410) @(negedge clk);
    press(START, 1'b0);
    for (int i = 0; i < 10; i++) press(MIN, 1'b0);
    for (int i = 0; i < 59; i++) press(SEC, 1'b0);
    press(START, 1'b0);
    repeat ($urandom_range(5, 30)) @(negedge clk);
    press(START, 1'b0);
    for (int i = 1; i <= 40; i += 3) push(cyc + i, "pause frozen");
    repeat (41) @(negedge clk);
    press(START, 1'b0);
    repeat ($urandom_range(10, 50)) @(negedge clk);
    press(CLR | START, 1'b0);
    for (int i = 0; i < 25; i++) begin
      press(pick[$urandom_range(6)], $urandom_range(1) == 1);
      repeat ($urandom_range(20)) @(negedge clk);
      push(cyc + 1, "random");
      @(negedge clk);
    end
    press(CLR, 1'b0);
    if (pm == 0 && ps == 0) press(SEC, 1'b0);
    press(START, 1'b0);
    repeat ($urandom_range(3, 20)) @(negedge clk);
    for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    mst = M_IDLE;
    pm = 0;
    ps = 0;
    push(cyc, "async reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(cyc + 1, "after reset");
    push(cyc + 6, "after reset idle");
    for (int k = 0; k < 2000 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d checks still pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Six-digit BCD countdown timer (MM:SS.cc) driven from the board clock, with pushbutton preset entry, start/pause control and an alarm output on expiry. It is the down-counting counterpart of the team's up-counting stopwatch. It reuses the same 100 Hz timebase idea and the same active-low seven-segment digit outputs, so both blocks drive the same display hardware.

## Interface
Parameters:
- TICK_DIV, 500000, clk cycles per 0.01 s tick (50 MHz to 100 Hz)
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- pb_start  in  1  start/pause/acknowledge button, active-low, asynchronous
- pb_min  in  1  preset minutes +1 button, active-low, asynchronous
- pb_sec  in  1  preset seconds +1 button, active-low, asynchronous
- pb_clr  in  1  clear/abort button, active-low, asynchronous
- seg0..seg5  out  7 each  active-low gfedcba digit codes. seg0 is centiseconds units; seg5 is minutes tens.
- running  out  1  high in RUN
- alarm  out  1  high in DONE

## Operation
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The accepted level changes only after DEB_CYCLES consecutive equal synchronized samples.
  - A 1-cycle press pulse is generated on each accepted high-to-low transition, so there is exactly one pulse per press.
- Press priority in the same cycle: clr > start > min > sec. Lower-priority pulses in that cycle are dropped.
- Registers:
  - preset: BCD MM:SS, 16 bits, range 00:00..59:59.
  - count: BCD MM:SS.cc, 24 bits.
- State machine: IDLE, RUN, PAUSE, DONE.
  - IDLE:
    - Display shows preset with cc = 00.
    - min press: MM+1, wrapping 59 to 00.
    - sec press: SS+1, wrapping 59 to 00.
    - start press with preset != 00:00: count <= {preset, 8'h00}, prescaler cleared, go to RUN.
    - start press with preset == 00:00: ignored.
  - RUN:
    - Display shows count. Each tick decrements count by one centisecond.
    - Borrow chain: a units digit goes 0 to 9 with borrow. Seconds-tens and minutes-tens digits go 0 to 5 with borrow. cc tens goes 0 to 9.
    - When the decrement produces 00:00.00, go to DONE on the same edge.
    - start press: go to PAUSE, count held.
    - min/sec presses: ignored.
  - PAUSE:
    - Display shows count, frozen.
    - start press: prescaler cleared, go to RUN.
    - min/sec presses: ignored.
  - DONE:
    - Display shows 00:00.00; alarm = 1.
    - start press: go to IDLE, preset retained.
  - Any state: clr press goes to IDLE. Preset is retained, count is cleared to 0, alarm drops.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for the cycle in which it equals TICK_DIV-1.
  - It only advances in RUN; it is held at 0 otherwise.
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - any other value = 1111111
- Reset (async): state IDLE, preset 00:00, count 0, prescaler 0, debouncers at accepted level high (released). Outputs: seg0..seg5 = 1000000, running = 0, alarm = 0.

## Timing
- Press latency: pin falling edge, then 2 sync cycles, then DEB_CYCLES, then a 1-cycle pulse. The state/register update occurs on the edge after the pulse.
- First decrement after entering RUN happens exactly TICK_DIV cycles after the transition edge. Subsequent decrements follow every TICK_DIV cycles.
- Tick and start press in the same RUN cycle: go to PAUSE, no decrement.
- Tick and clr in the same cycle: go to IDLE, no decrement.
- running, alarm and seg outputs are registered or decoded from registered state. They reflect a transition in the cycle after the transition edge, with no combinational path from the buttons.
- Reset asserted mid-RUN: all state returns to reset values immediately (asynchronously). After release, the block sits in IDLE until a press.
- Count never underflows. 00:00.00 is reached only via DONE, never decremented.

## Test plan
Bench uses TICK_DIV=4, DEB_CYCLES=2.
- Reset, then idle -> seg0..seg5 = 1000000, running = 0, alarm = 0. Start press with preset 00:00 -> still IDLE.
- 61 min presses + 2 sec presses -> preset displays 01:02.00 (minutes wrapped 59 to 00 to 01). A 3-cycle bounce shorter than DEB_CYCLES produces no extra increment.
- Preset 00:01, start -> running = 1. Count 00:00.99 appears 4 cycles after entry. After 100 ticks (400 cycles) count reaches 00:00.00, alarm = 1, running = 0 in the same cycle.
- Preset 10:00, start, 1 tick -> 09:59.99, checking the borrow across all digits. Start press -> PAUSE, display frozen for 40 cycles. Start press again -> resumes, next decrement 4 cycles later.
- RUN with clr and start pulses forced in the same cycle -> IDLE, preset shown, alarm = 0. Start press in DONE -> IDLE with preset retained.
- Assert rst mid-RUN -> outputs at reset values immediately, preset = 00:00.
